stf_autocorr: RTL and testbench

Delay-and-correlate stage for 802.11a short-training-sequence detection and coarse frequency-offset estimation. It sits directly downstream of the 16-sample delay line. Each cycle it takes a time-aligned pair (current sample, sample delayed by 16) and maintains running window sums:
- P = Σ cur·conj(dly), the complex autocorrelation;
- E = Σ |cur|², the energy.

The downstream plateau detector and phase (CORDIC) stage consume P and E.

---
 rtl/stf_autocorr_pkg.sv | 27 ++
 rtl/corr_window_buf.sv | 47 ++++
 rtl/stf_autocorr.sv | 136 +++++++++++++
 tb/tb_stf_autocorr.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/stf_autocorr_pkg.sv
// Shared widths and helpers for the STF delay-and-correlate stage.
// Widths derive from the packed complex sample width and window length.
package stf_autocorr_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int WINDOW_DEF = 16;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int iq_w(input int dw);
        return dw / 2;
    endfunction

    function automatic int prod_w(input int dw);
        return dw + 1;
    endfunction

    function automatic int acc_width(input int dw, input int win);
        return dw + 1 + clog2(win);
    endfunction

endpackage

// File: rtl/corr_window_buf.sv
// Circular buffer of product triples with read-before-write at one pointer.
// Tracks fill level so stale contents never leave the buffer.
module corr_window_buf
    import stf_autocorr_pkg::*;
#(
    parameter int WINDOW = WINDOW_DEF,
    parameter int WORD_W = 3 * prod_w(DATA_W_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [WORD_W-1:0] wr_data,
    output logic [WORD_W-1:0] rd_data,
    output logic              full,
    output logic              last
);

    localparam int PTR_W = clog2(WINDOW);
    localparam int CNT_W = PTR_W + 1;

    logic [WORD_W-1:0] mem [WINDOW];
    logic [PTR_W-1:0]  ptr;
    logic [CNT_W-1:0]  fill_cnt;

    assign full    = (fill_cnt == CNT_W'(WINDOW));
    assign last    = (fill_cnt == CNT_W'(WINDOW - 1));
    assign rd_data = full ? mem[ptr] : '0;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            fill_cnt <= '0;
        end else if (wr_en) begin
            ptr <= (ptr == PTR_W'(WINDOW - 1)) ? '0 : ptr + 1'b1;
            if (!full) begin
                fill_cnt <= fill_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stf_autocorr.sv
// Delay-and-correlate: running window sums of cur*conj(dly) and |cur|^2.
// Products, combine, accumulate, then registered outputs (3-cycle latency).
module stf_autocorr
    import stf_autocorr_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W_DEF,
    parameter int WINDOW     = WINDOW_DEF,
    parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, WINDOW)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  pair_valid,
    input  logic [DATA_WIDTH-1:0] sample_cur,
    input  logic [DATA_WIDTH-1:0] sample_dly,
    output logic                  corr_valid,
    output logic [ACC_WIDTH-1:0]  corr_i,
    output logic [ACC_WIDTH-1:0]  corr_q,
    output logic [ACC_WIDTH-1:0]  energy
);

    localparam int IW = iq_w(DATA_WIDTH);
    localparam int PW = prod_w(DATA_WIDTH);
    localparam int DW = DATA_WIDTH;

    logic clr;
    logic v1, v2, v3;

    logic signed [IW-1:0] ci, cq, di, dq;

    logic signed [DW-1:0] m_idi, m_qdq, m_qdi, m_idq, m_ii, m_qq;

    logic signed [PW-1:0] s_r, s_q;
    logic        [PW-1:0] s_e;

    logic [3*PW-1:0]      old_w;
    logic signed [PW-1:0] o_r, o_q;
    logic        [PW-1:0] o_e;
    logic                 full, last;

    logic signed [ACC_WIDTH-1:0] acc_i, acc_q;
    logic        [ACC_WIDTH-1:0] acc_e;

    assign clr = rst || !enable;

    assign ci = sample_cur[DW-1:IW];
    assign cq = sample_cur[IW-1:0];
    assign di = sample_dly[DW-1:IW];
    assign dq = sample_dly[IW-1:0];

    // Stage 1: full-precision products
    always_ff @(posedge clk) begin
        if (clr) begin
            v1 <= 1'b0;
        end else begin
            v1 <= pair_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (pair_valid) begin
            m_idi <= DW'(ci) * DW'(di);
            m_qdq <= DW'(cq) * DW'(dq);
            m_qdi <= DW'(cq) * DW'(di);
            m_idq <= DW'(ci) * DW'(dq);
            m_ii  <= DW'(ci) * DW'(ci);
            m_qq  <= DW'(cq) * DW'(cq);
        end
    end

    // Stage 2: combine into the product triple
    always_ff @(posedge clk) begin
        if (clr) begin
            v2 <= 1'b0;
        end else begin
            v2 <= v1;
        end
    end

    always_ff @(posedge clk) begin
        if (v1) begin
            s_r <= PW'(m_idi) + PW'(m_qdq);
            s_q <= PW'(m_qdi) - PW'(m_idq);
            s_e <= PW'($unsigned(m_ii)) + PW'($unsigned(m_qq));
        end
    end

    corr_window_buf #(
        .WINDOW (WINDOW),
        .WORD_W (3 * PW)
    ) u_buf (
        .clk     (clk),
        .rst     (clr),
        .wr_en   (v2),
        .wr_data ({s_r, s_q, s_e}),
        .rd_data (old_w),
        .full    (full),
        .last    (last)
    );

    assign {o_r, o_q, o_e} = old_w;

    // Stage 3: slide the window
    always_ff @(posedge clk) begin
        if (clr) begin
            v3    <= 1'b0;
            acc_i <= '0;
            acc_q <= '0;
            acc_e <= '0;
        end else begin
            v3 <= v2 && (full || last);
            if (v2) begin
                acc_i <= acc_i + ACC_WIDTH'(s_r) - ACC_WIDTH'(o_r);
                acc_q <= acc_q + ACC_WIDTH'(s_q) - ACC_WIDTH'(o_q);
                acc_e <= acc_e + ACC_WIDTH'(s_e) - ACC_WIDTH'(o_e);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            corr_valid <= 1'b0;
            corr_i     <= '0;
            corr_q     <= '0;
            energy     <= '0;
        end else begin
            corr_valid <= v3;
            if (v3) begin
                corr_i <= acc_i;
                corr_q <= acc_q;
                energy <= acc_e;
            end
        end
    end

endmodule

// File: tb/tb_stf_autocorr.sv
// Self-checking bench for stf_autocorr against a window-sum model.
// Directed scenarios with literal pins, then randomized traffic.
module tb_stf_autocorr;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        pair_valid;
    logic [31:0] sample_cur;
    logic [31:0] sample_dly;
    logic        corr_valid;
    logic [36:0] corr_i;
    logic [36:0] corr_q;
    logic [36:0] energy;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    bit started = 0;

    stf_autocorr dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .pair_valid (pair_valid),
        .sample_cur (sample_cur),
        .sample_dly (sample_dly),
        .corr_valid (corr_valid),
        .corr_i     (corr_i),
        .corr_q     (corr_q),
        .energy     (energy)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input longint a, input longint e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0d want %0d", n, a, e);
        end
    endtask

    // Model: keep the last 16 accepted pairs, sum directly, delay 3 edges.
    typedef struct {
        bit     v;
        longint i;
        longint q;
        longint e;
    } exp_t;

    longint hr[$];
    longint hq[$];
    longint he[$];
    exp_t   pipe [3];
    bit     exp_v = 0;
    longint hold_i = 0;
    longint hold_q = 0;
    longint hold_e = 0;

    always @(posedge clk) begin
        if (rst || !enable) begin
            hr.delete();
            hq.delete();
            he.delete();
            for (int k = 0; k < 3; k++) pipe[k] = '{0, 0, 0, 0};
            exp_v  = 0;
            hold_i = 0;
            hold_q = 0;
            hold_e = 0;
        end else begin
            exp_v = pipe[2].v;
            if (pipe[2].v) begin
                hold_i = pipe[2].i;
                hold_q = pipe[2].q;
                hold_e = pipe[2].e;
            end
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = '{0, 0, 0, 0};
            if (pair_valid) begin
                longint ci, cq, di, dq;
                ci = longint'($signed(sample_cur[31:16]));
                cq = longint'($signed(sample_cur[15:0]));
                di = longint'($signed(sample_dly[31:16]));
                dq = longint'($signed(sample_dly[15:0]));
                hr.push_back(ci * di + cq * dq);
                hq.push_back(cq * di - ci * dq);
                he.push_back(ci * ci + cq * cq);
                if (hr.size() > 16) begin
                    void'(hr.pop_front());
                    void'(hq.pop_front());
                    void'(he.pop_front());
                end
                if (hr.size() == 16) begin
                    pipe[0].v = 1;
                    foreach (hr[k]) begin
                        pipe[0].i += hr[k];
                        pipe[0].q += hq[k];
                        pipe[0].e += he[k];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("corr_valid", longint'(corr_valid), longint'(exp_v));
            chk("corr_i", longint'($signed(corr_i)), hold_i);
            chk("corr_q", longint'($signed(corr_q)), hold_q);
            chk("energy", longint'(energy), hold_e);
            if (corr_valid === 1'b1) pulses++;
        end
    end

    function automatic logic [31:0] pk(input int i, input int q);
        logic [15:0] a, b;
        a = i[15:0];
        b = q[15:0];
        return {a, b};
    endfunction

    task automatic step(input bit v, input logic [31:0] c, input logic [31:0] d);
        pair_valid = v;
        sample_cur = c;
        sample_dly = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 32'h0, 32'h0);
    endtask

    task automatic flush_en();
        enable = 0;
        step(1, pk(1000, 0), pk(1000, 0));
        enable = 1;
    endtask

    task automatic lit(input string n, input longint ei, input longint eq,
                       input longint ee);
        chk({n, "_i"}, longint'($signed(corr_i)), ei);
        chk({n, "_q"}, longint'($signed(corr_q)), eq);
        chk({n, "_e"}, longint'(energy), ee);
        chk({n, "_model_i"}, hold_i, ei);
    endtask

    initial begin
        int p0;
        rst        = 1;
        enable     = 1;
        pair_valid = 0;
        sample_cur = 0;
        sample_dly = 0;
        @(posedge clk);
        #1;
        idle(2);
        started = 1;
        rst     = 0;
        lit("reset", 0, 0, 0);
        chk("reset_valid", longint'(corr_valid), 0);

        // constant pairs, 20 back-to-back
        p0 = pulses;
        repeat (20) step(1, pk(1000, 0), pk(1000, 0));
        idle(5);
        lit("const", 16000000, 0, 16000000);
        chk("const_pulses", pulses - p0, 5);

        flush_en();
        repeat (16) step(1, pk(0, 1000), pk(1000, 0));
        idle(5);
        lit("quad", 0, 16000000, 16000000);

        flush_en();
        repeat (16) step(1, pk(1000, 0), pk(1000, 0));
        repeat (8) step(1, pk(0, 0), pk(1000, 0));
        idle(5);
        lit("slide", 8000000, 0, 8000000);

        flush_en();
        repeat (16) step(1, pk(-32768, -32768), pk(-32768, -32768));
        idle(5);
        lit("fullscale", 64'd34359738368, 0, 64'd34359738368);

        flush_en();
        p0 = pulses;
        repeat (20) begin
            step(1, pk(1000, 0), pk(1000, 0));
            step(0, pk(7, 7), pk(7, 7));
        end
        idle(5);
        lit("gapped", 16000000, 0, 16000000);
        chk("gapped_pulses", pulses - p0, 5);

        flush_en();
        p0 = pulses;
        repeat (10) step(1, pk(500, 300), pk(500, 0));
        flush_en();
        repeat (16) step(1, pk(1000, 0), pk(1000, 0));
        idle(5);
        lit("en_flush", 16000000, 0, 16000000);
        chk("en_flush_pulses", pulses - p0, 1);

        flush_en();
        p0 = pulses;
        repeat (10) step(1, pk(500, 300), pk(500, 0));
        rst = 1;
        step(1, pk(1000, 0), pk(1000, 0));
        rst = 0;
        repeat (16) step(1, pk(1000, 0), pk(1000, 0));
        idle(5);
        lit("rst_flush", 16000000, 0, 16000000);
        chk("rst_flush_pulses", pulses - p0, 1);

        for (int n = 0; n < 600; n++) begin
            rst    = ($urandom_range(99) == 0);
            enable = ($urandom_range(59) != 0);
            step($urandom_range(9) < 8, $urandom, $urandom);
        end
        rst    = 0;
        enable = 1;
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
